// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: op encodings and
// fault flag bit positions.
package pc_pkg;

  localparam logic [2:0] PC_OP_INC    = 3'd0;
  localparam logic [2:0] PC_OP_JUMP   = 3'd1;
  localparam logic [2:0] PC_OP_BRANCH = 3'd2;
  localparam logic [2:0] PC_OP_CALL   = 3'd3;
  localparam logic [2:0] PC_OP_RET    = 3'd4;
  localparam logic [2:0] PC_OP_HOLD   = 3'd5;

  // Encodings 6 and 7 are not named; the sequencer treats them as INC.
  typedef enum logic [2:0] {
    OP_INC    = PC_OP_INC,
    OP_JUMP   = PC_OP_JUMP,
    OP_BRANCH = PC_OP_BRANCH,
    OP_CALL   = PC_OP_CALL,
    OP_RET    = PC_OP_RET,
    OP_HOLD   = PC_OP_HOLD
  } pc_op_e;

  localparam int FAULT_OVF = 0;
  localparam int FAULT_UNF = 1;

endpackage

// File: rtl/pc_return_stack.sv
// LIFO of return addresses with a depth counter. The caller guarantees that
// push and pop are never asserted together, and never push when full or pop
// when empty.
module pc_return_stack #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [CW-1:0]     count;
  logic [IW-1:0]     wr_idx;
  logic [IW-1:0]     rd_idx;

  // The next free slot is at count; the top entry sits one below it.
  assign wr_idx = IW'(count);
  assign rd_idx = IW'(count - CW'(1));
  assign dout   = mem[rd_idx];
  assign empty  = (count == '0);
  assign full   = (count == CW'(STACK_DEPTH));

  // Depth counter: clearing it on reset is enough to discard every entry.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    if (!reset_n) begin
      count <= '0;
    end else if (push) begin
      count <= count + CW'(1);
    end else if (pop) begin
      count <= count - CW'(1);
    end
  end

  // Entry storage written on push.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; entries above count are never read, so
    // clearing them would only add reset fan-out.
    if (push) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: increment, absolute jump, relative branch,
// call/return through a hardware stack, hold and stall, with sticky
// overflow/underflow flags.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] offset,
  output logic [ADDR_W-1:0] pc,
  output logic              stack_empty,
  output logic              stack_full,
  output logic [1:0]        fault
);

  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] stack_top;
  logic [1:0]        fault_next;
  logic              push;
  logic              pop;

  assign pc_inc = pc + ADDR_W'(1);

  pc_return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (pc_inc),
    .dout    (stack_top),
    .empty   (stack_empty),
    .full    (stack_full)
  );

  // Next-PC mux, stack control and fault update; a stall leaves everything
  // at its current value.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    pc_next    = pc;
    fault_next = fault;
    push       = 1'b0;
    pop        = 1'b0;
    if (en) begin
      case (op)
        OP_JUMP:   pc_next = target;
        OP_BRANCH: pc_next = pc + offset;
        OP_CALL: begin
          if (!stack_full) begin
            push    = 1'b1;
            pc_next = target;
          end else begin
            pc_next               = pc_inc;
            fault_next[FAULT_OVF] = 1'b1;
          end
        end
        OP_RET: begin
          if (!stack_empty) begin
            pop     = 1'b1;
            pc_next = stack_top;
          end else begin
            pc_next               = pc_inc;
            fault_next[FAULT_UNF] = 1'b1;
          end
        end
        OP_HOLD:   pc_next = pc;
        default:   pc_next = pc_inc;
      endcase
    end
  end

  // PC and sticky fault registers; reset wins over en and op.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc    <= RESET_VEC;
      fault <= 2'b00;
    end else begin
      pc    <= pc_next;
      fault <= fault_next;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (ADDR_W=8, STACK_DEPTH=2, RESET_VEC=8'h20).
module tb_pc_sequencer;
  import pc_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic [2:0] op;
  logic [7:0] target;
  logic [7:0] offset;
  logic [7:0] pc;
  logic       stack_empty;
  logic       stack_full;
  logic [1:0] fault;

  int checks   = 0;
  int failures = 0;

  // One cycle of stimulus and the state expected after that edge.
  typedef struct {
    logic       rst_n;
    logic       en;
    logic [2:0] op;
    logic [7:0] tgt;
    logic [7:0] off;
    logic [7:0] pc;
    logic       emp;
    logic       full;
    logic [1:0] flt;
  } vec_t;

  pc_sequencer #(
    .ADDR_W      (8),
    .STACK_DEPTH (2),
    .RESET_VEC   (8'h20)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .op          (op),
    .target      (target),
    .offset      (offset),
    .pc          (pc),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  // Apply one vector across a rising edge; outputs are sampled 1 time unit later.
  task automatic drive(input vec_t v);
    reset_n = v.rst_n;
    en      = v.en;
    op      = v.op;
    target  = v.tgt;
    offset  = v.off;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t v [7];
    v[0] = '{1'b0, 1'b1, OP_INC, 8'h00, 8'h00, 8'h20, 1'b1, 1'b0, 2'b00};
    v[1] = '{1'b0, 1'b1, OP_INC, 8'h00, 8'h00, 8'h20, 1'b1, 1'b0, 2'b00};
    v[2] = '{1'b1, 1'b1, OP_INC, 8'h00, 8'h00, 8'h21, 1'b1, 1'b0, 2'b00};
    v[3] = '{1'b1, 1'b1, OP_INC, 8'h00, 8'h00, 8'h22, 1'b1, 1'b0, 2'b00};
    v[4] = '{1'b1, 1'b1, OP_INC, 8'h00, 8'h00, 8'h23, 1'b1, 1'b0, 2'b00};
    v[5] = '{1'b1, 1'b1, OP_INC, 8'h00, 8'h00, 8'h24, 1'b1, 1'b0, 2'b00};
    v[6] = '{1'b1, 1'b1, OP_INC, 8'h00, 8'h00, 8'h25, 1'b1, 1'b0, 2'b00};
    for (int i = 0; i < 7; i++) begin
      drive(v[i]);
      checks++;
      if ({pc, stack_empty, stack_full, fault} !== {v[i].pc, v[i].emp, v[i].full, v[i].flt}) begin
        failures++;
        $display("FAIL reset[%0d] got pc=%h empty=%b full=%b fault=%b want pc=%h empty=%b full=%b fault=%b",
                 i, pc, stack_empty, stack_full, fault, v[i].pc, v[i].emp, v[i].full, v[i].flt);
      end
    end
  endtask

  task automatic test_jump_branch();
    vec_t v [6];
    v[0] = '{1'b1, 1'b1, OP_JUMP,   8'hFE, 8'h00, 8'hFE, 1'b1, 1'b0, 2'b00};
    v[1] = '{1'b1, 1'b1, OP_INC,    8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 2'b00};
    v[2] = '{1'b1, 1'b1, OP_INC,    8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00};
    v[3] = '{1'b1, 1'b1, OP_JUMP,   8'h10, 8'h00, 8'h10, 1'b1, 1'b0, 2'b00};
    v[4] = '{1'b1, 1'b1, OP_BRANCH, 8'h77, 8'hF0, 8'h00, 1'b1, 1'b0, 2'b00};
    v[5] = '{1'b1, 1'b1, OP_BRANCH, 8'h77, 8'h05, 8'h05, 1'b1, 1'b0, 2'b00};
    for (int i = 0; i < 6; i++) begin
      drive(v[i]);
      checks++;
      if ({pc, stack_empty, stack_full, fault} !== {v[i].pc, v[i].emp, v[i].full, v[i].flt}) begin
        failures++;
        $display("FAIL jump_branch[%0d] got pc=%h empty=%b full=%b fault=%b want pc=%h empty=%b full=%b fault=%b",
                 i, pc, stack_empty, stack_full, fault, v[i].pc, v[i].emp, v[i].full, v[i].flt);
      end
    end
  endtask

  task automatic test_nested_calls();
    vec_t v [8];
    v[0] = '{1'b1, 1'b1, OP_JUMP, 8'h10, 8'h00, 8'h10, 1'b1, 1'b0, 2'b00};
    v[1] = '{1'b1, 1'b1, OP_CALL, 8'h40, 8'h00, 8'h40, 1'b0, 1'b0, 2'b00};
    v[2] = '{1'b1, 1'b1, OP_CALL, 8'h80, 8'h00, 8'h80, 1'b0, 1'b1, 2'b00};
    v[3] = '{1'b1, 1'b1, OP_RET,  8'h00, 8'h00, 8'h41, 1'b0, 1'b0, 2'b00};
    v[4] = '{1'b1, 1'b1, OP_RET,  8'h00, 8'h00, 8'h11, 1'b1, 1'b0, 2'b00};
    v[5] = '{1'b1, 1'b1, OP_HOLD, 8'h55, 8'h33, 8'h11, 1'b1, 1'b0, 2'b00};
    v[6] = '{1'b1, 1'b1, 3'd6,    8'h55, 8'h33, 8'h12, 1'b1, 1'b0, 2'b00};
    v[7] = '{1'b1, 1'b1, 3'd7,    8'h55, 8'h33, 8'h13, 1'b1, 1'b0, 2'b00};
    for (int i = 0; i < 8; i++) begin
      drive(v[i]);
      checks++;
      if ({pc, stack_empty, stack_full, fault} !== {v[i].pc, v[i].emp, v[i].full, v[i].flt}) begin
        failures++;
        $display("FAIL nested_calls[%0d] got pc=%h empty=%b full=%b fault=%b want pc=%h empty=%b full=%b fault=%b",
                 i, pc, stack_empty, stack_full, fault, v[i].pc, v[i].emp, v[i].full, v[i].flt);
      end
    end
  endtask

  task automatic test_overflow_underflow();
    vec_t v [8];
    v[0] = '{1'b0, 1'b1, OP_INC,  8'h00, 8'h00, 8'h20, 1'b1, 1'b0, 2'b00};
    v[1] = '{1'b1, 1'b1, OP_CALL, 8'h40, 8'h00, 8'h40, 1'b0, 1'b0, 2'b00};
    v[2] = '{1'b1, 1'b1, OP_CALL, 8'h80, 8'h00, 8'h80, 1'b0, 1'b1, 2'b00};
    v[3] = '{1'b1, 1'b1, OP_CALL, 8'h90, 8'h00, 8'h81, 1'b0, 1'b1, 2'b01};
    v[4] = '{1'b0, 1'b1, OP_INC,  8'h00, 8'h00, 8'h20, 1'b1, 1'b0, 2'b00};
    v[5] = '{1'b1, 1'b1, OP_RET,  8'h00, 8'h00, 8'h21, 1'b1, 1'b0, 2'b10};
    v[6] = '{1'b1, 1'b1, OP_INC,  8'h00, 8'h00, 8'h22, 1'b1, 1'b0, 2'b10};
    v[7] = '{1'b1, 1'b1, OP_INC,  8'h00, 8'h00, 8'h23, 1'b1, 1'b0, 2'b10};
    for (int i = 0; i < 8; i++) begin
      drive(v[i]);
      checks++;
      if ({pc, stack_empty, stack_full, fault} !== {v[i].pc, v[i].emp, v[i].full, v[i].flt}) begin
        failures++;
        $display("FAIL ovf_unf[%0d] got pc=%h empty=%b full=%b fault=%b want pc=%h empty=%b full=%b fault=%b",
                 i, pc, stack_empty, stack_full, fault, v[i].pc, v[i].emp, v[i].full, v[i].flt);
      end
    end
  endtask

  // Continues from pc=23 with the underflow flag set.
  task automatic test_stall();
    vec_t v [6];
    v[0] = '{1'b1, 1'b1, OP_CALL, 8'h50, 8'h00, 8'h50, 1'b0, 1'b0, 2'b10};
    v[1] = '{1'b1, 1'b0, OP_CALL, 8'h99, 8'h00, 8'h50, 1'b0, 1'b0, 2'b10};
    v[2] = '{1'b1, 1'b0, OP_CALL, 8'h99, 8'h00, 8'h50, 1'b0, 1'b0, 2'b10};
    v[3] = '{1'b1, 1'b0, OP_CALL, 8'h99, 8'h00, 8'h50, 1'b0, 1'b0, 2'b10};
    v[4] = '{1'b1, 1'b1, OP_INC,  8'h00, 8'h00, 8'h51, 1'b0, 1'b0, 2'b10};
    v[5] = '{1'b1, 1'b1, OP_RET,  8'h00, 8'h00, 8'h24, 1'b1, 1'b0, 2'b10};
    for (int i = 0; i < 6; i++) begin
      drive(v[i]);
      checks++;
      if ({pc, stack_empty, stack_full, fault} !== {v[i].pc, v[i].emp, v[i].full, v[i].flt}) begin
        failures++;
        $display("FAIL stall[%0d] got pc=%h empty=%b full=%b fault=%b want pc=%h empty=%b full=%b fault=%b",
                 i, pc, stack_empty, stack_full, fault, v[i].pc, v[i].emp, v[i].full, v[i].flt);
      end
    end
  endtask

  task automatic test_reset_mid();
    vec_t v [5];
    v[0] = '{1'b0, 1'b1, OP_INC,  8'h00, 8'h00, 8'h20, 1'b1, 1'b0, 2'b00};
    v[1] = '{1'b1, 1'b1, OP_CALL, 8'h40, 8'h00, 8'h40, 1'b0, 1'b0, 2'b00};
    v[2] = '{1'b1, 1'b1, OP_CALL, 8'h80, 8'h00, 8'h80, 1'b0, 1'b1, 2'b00};
    v[3] = '{1'b0, 1'b1, OP_RET,  8'h00, 8'h00, 8'h20, 1'b1, 1'b0, 2'b00};
    v[4] = '{1'b1, 1'b1, OP_RET,  8'h00, 8'h00, 8'h21, 1'b1, 1'b0, 2'b10};
    for (int i = 0; i < 5; i++) begin
      drive(v[i]);
      checks++;
      if ({pc, stack_empty, stack_full, fault} !== {v[i].pc, v[i].emp, v[i].full, v[i].flt}) begin
        failures++;
        $display("FAIL reset_mid[%0d] got pc=%h empty=%b full=%b fault=%b want pc=%h empty=%b full=%b fault=%b",
                 i, pc, stack_empty, stack_full, fault, v[i].pc, v[i].emp, v[i].full, v[i].flt);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v [9];
    v[0] = '{1'b0, 1'b1, OP_INC,  8'h00, 8'h00, 8'h20, 1'b1, 1'b0, 2'b00};
    v[1] = '{1'b1, 1'b1, OP_CALL, 8'h60, 8'h00, 8'h60, 1'b0, 1'b0, 2'b00};
    v[2] = '{1'b1, 1'b1, OP_RET,  8'h00, 8'h00, 8'h21, 1'b1, 1'b0, 2'b00};
    v[3] = '{1'b1, 1'b1, OP_CALL, 8'h70, 8'h00, 8'h70, 1'b0, 1'b0, 2'b00};
    v[4] = '{1'b1, 1'b1, OP_CALL, 8'h30, 8'h00, 8'h30, 1'b0, 1'b1, 2'b00};
    v[5] = '{1'b1, 1'b1, OP_RET,  8'h00, 8'h00, 8'h71, 1'b0, 1'b0, 2'b00};
    v[6] = '{1'b1, 1'b1, OP_CALL, 8'hA0, 8'h00, 8'hA0, 1'b0, 1'b1, 2'b00};
    v[7] = '{1'b1, 1'b1, OP_RET,  8'h00, 8'h00, 8'h72, 1'b0, 1'b0, 2'b00};
    v[8] = '{1'b0, 1'b0, OP_CALL, 8'h99, 8'h00, 8'h20, 1'b1, 1'b0, 2'b00};
    for (int i = 0; i < 9; i++) begin
      drive(v[i]);
      checks++;
      if ({pc, stack_empty, stack_full, fault} !== {v[i].pc, v[i].emp, v[i].full, v[i].flt}) begin
        failures++;
        $display("FAIL back_to_back[%0d] got pc=%h empty=%b full=%b fault=%b want pc=%h empty=%b full=%b fault=%b",
                 i, pc, stack_empty, stack_full, fault, v[i].pc, v[i].emp, v[i].full, v[i].flt);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    en      = 1'b0;
    op      = OP_INC;
    target  = '0;
    offset  = '0;
    test_reset();
    test_jump_branch();
    test_nested_calls();
    test_overflow_underflow();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
